sync_fifo_prog: RTL and testbench

Single-clock, parametrised FIFO for buffering data between producer and consumer logic in the same clock domain. It is the single-domain successor to the dual-clock FIFO: all 2**FIFO_DEPTH_WIDTH entries are usable, with programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and an occupancy count. A compile-time first-word-fall-through (FWFT) read mode is available.

---
 rtl/sync_fifo_prog.sv | 156 +++++++++++++++
 tb/tb_sync_fifo_prog.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
//
// Single-clock FIFO with all 2**FIFO_DEPTH_WIDTH entries usable, programmable
// almost-full / almost-empty thresholds, sticky overflow / underflow flags and
// an occupancy count.
//
// Build option:
//   SYNC_FIFO_FWFT_EN  defined   -> first-word-fall-through read: data_read
//                                   always shows the head word, data_valid =
//                                   !empty, read acknowledges/pops the head.
//                      undefined -> registered read: data_read is loaded on an
//                                   accepted read and data_valid pulses for one
//                                   cycle afterwards.
//
// Parameters:
//   DATA_WIDTH        width of each stored word
//   FIFO_DEPTH_WIDTH  log2 of the depth
//   AF_THRESH         almost_full when count >= AF_THRESH   (1..DEPTH)
//   AE_THRESH         almost_empty when count <= AE_THRESH  (0..DEPTH-1)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   write         write request, data_write sampled with it
//   data_write    write data
//   read          read request (head acknowledge in FWFT mode)
//   clear_err     one-cycle pulse clearing overflow/underflow
//   data_read     read data
//   data_valid    data_read holds a valid word
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   data_count    current occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected because the FIFO was full
//   underflow     sticky: a read was rejected because the FIFO was empty
// -----------------------------------------------------------------------------
module sync_fifo_prog #(
    parameter int DATA_WIDTH       = 8,
    parameter int FIFO_DEPTH_WIDTH = 5,
    parameter int AF_THRESH        = (1 << FIFO_DEPTH_WIDTH) - 4,
    parameter int AE_THRESH        = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write,
    input  logic [DATA_WIDTH-1:0]       data_write,
    input  logic                        read,
    input  logic                        clear_err,
    output logic [DATA_WIDTH-1:0]       data_read,
    output logic                        data_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [FIFO_DEPTH_WIDTH:0]   data_count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int              DEPTH     = 1 << FIFO_DEPTH_WIDTH;
    localparam int              CW        = FIFO_DEPTH_WIDTH + 1;
    localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_CNT    = CW'(AF_THRESH);
    localparam logic [CW-1:0]   AE_CNT    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0]       mem [DEPTH];
    logic [FIFO_DEPTH_WIDTH-1:0] wr_ptr;
    logic [FIFO_DEPTH_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]               count;

    // Request semantics: a write is accepted when write=1 and the FIFO is not
    // full; a read is accepted when read=1 and the FIFO is not empty. Both use
    // the state before the edge, so at full a simultaneous read frees no room
    // for the write, and at empty a simultaneous write is not yet readable.
    // A request that is not accepted is dropped and raises the sticky error.
    logic wr_acc;
    logic rd_acc;

    assign wr_acc = write & ~full;
    assign rd_acc = read & ~empty;

    // Flags decode straight from the count register (post-edge state).
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign data_count   = count;

    // Storage is deliberately not reset; only pointers and count are.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= data_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + FIFO_DEPTH_WIDTH'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky errors; a new error event in the same cycle beats clear_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write && full) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (read && empty) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is always on the output; its value while empty is meaningless.
    assign data_read  = mem[rd_ptr];
    assign data_valid = ~empty;
`else
    // Registered read: data_read holds its last value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_read  <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            if (rd_acc) begin
                data_read <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int AF    = 28;
  localparam int AE    = 4;
`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write = 1'b0;
  logic [DW-1:0] data_write = '0;
  logic          read = 1'b0;
  logic          clear_err = 1'b0;
  logic [DW-1:0] data_read;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   data_count;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  sync_fifo_prog #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH_WIDTH(AW),
    .AF_THRESH(AF),
    .AE_THRESH(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .write(write),
    .data_write(data_write),
    .read(read),
    .clear_err(clear_err),
    .data_read(data_read),
    .data_valid(data_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .data_count(data_count),
    .overflow(overflow),
    .underflow(underflow)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_data;
  bit            m_valid;
  bit            m_ovf;
  bit            m_unf;
  int            n_cmp = 0;
  int            n_fail = 0;

  // Update the model from the rules: occupancy is the queue length, a write
  // fits only below DEPTH, a read succeeds only on a non-empty queue.
  task automatic model_edge(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    int  sz;
    bit  wa;
    bit  ra;
    sz = exp_q.size();
    wa = w && (sz < DEPTH);
    ra = r && (sz > 0);
    if (!FWFT) m_valid = ra;
    if (ra) begin
      if (FWFT) void'(exp_q.pop_front());
      else m_data = exp_q.pop_front();
    end
    if (wa) exp_q.push_back(d);
    if (w && sz == DEPTH) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (r && sz == 0) m_unf = 1'b1;
    else if (c) m_unf = 1'b0;
    if (FWFT) begin
      m_valid = (exp_q.size() > 0);
      if (m_valid) m_data = exp_q[0];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    write = w;
    data_write = d;
    read = r;
    clear_err = c;
    @(posedge clk);
    model_edge(w, d, r, c);
    #1;
    write = 1'b0;
    read = 1'b0;
    clear_err = 1'b0;
  endtask

  // Reset edge carries random requests that must be ignored.
  task automatic do_reset();
    rst = 1'b1;
    write = 1'($urandom);
    read = 1'($urandom);
    clear_err = 1'($urandom);
    data_write = DW'($urandom);
    @(posedge clk);
    exp_q.delete();
    m_data = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    rst = 1'b0;
    write = 1'b0;
    read = 1'b0;
    clear_err = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", data_valid); end
    if (!FWFT) begin
      n_cmp++; if (data_read !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h exp 00", data_read); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b exp 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b exp 0", full); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae: got %b exp 1", almost_empty); end
    n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %b exp 0", almost_full); end
    n_cmp++; if (data_count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", data_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b exp 0", overflow); end
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf: got %b exp 0", underflow); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i <= 40; i++) begin
      cycle(1'b1, DW'(i), 1'b0, 1'b0);
      n_cmp++; if (data_count !== 6'(exp_q.size())) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, data_count, exp_q.size()); end
      n_cmp++; if (full !== (exp_q.size() == DEPTH)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b", i, full); end
      n_cmp++; if (almost_full !== (exp_q.size() >= AF)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b", i, almost_full); end
      n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL fill_ovf[%0d]: got %b exp %b", i, overflow, m_ovf); end
    end
    // Independent anchor: 32 words stored, overflow raised after write 33.
    n_cmp++; if (data_count !== 6'd32 || full !== 1'b1 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL fill_end: count %0d full %b ovf %b exp 32 1 1", data_count, full, overflow);
    end
  endtask

  // Runs straight after test_fill; checks words 0..31 come back in order.
  task automatic test_drain();
    int nxt;
    nxt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (data_valid !== m_valid) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b exp %b", i, data_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (data_read !== m_data) begin n_fail++; $display("FAIL drain_data[%0d]: got %h exp %h", i, data_read, m_data); end
      end
      if (!FWFT && m_valid) begin
        n_cmp++; if (data_read !== DW'(nxt)) begin n_fail++; $display("FAIL drain_order[%0d]: got %h exp %h", i, data_read, nxt[7:0]); end
        nxt++;
      end
      n_cmp++; if (empty !== (exp_q.size() == 0)) begin n_fail++; $display("FAIL drain_empty[%0d]: got %b", i, empty); end
      n_cmp++; if (almost_empty !== (exp_q.size() <= AE)) begin n_fail++; $display("FAIL drain_ae[%0d]: got %b", i, almost_empty); end
      n_cmp++; if (underflow !== m_unf) begin n_fail++; $display("FAIL drain_unf[%0d]: got %b exp %b", i, underflow, m_unf); end
    end
    if (!FWFT) begin
      n_cmp++; if (nxt !== 32) begin n_fail++; $display("FAIL drain_total: got %0d exp 32", nxt); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i <= 50; i++) begin
      cycle(1'b1, DW'(i), 1'b1, 1'b0);
      n_cmp++; if (data_count !== 6'(exp_q.size()) || data_count > 6'd1) begin n_fail++; $display("FAIL sim_count[%0d]: got %0d exp %0d", i, data_count, exp_q.size()); end
      n_cmp++; if (data_valid !== m_valid) begin n_fail++; $display("FAIL sim_valid[%0d]: got %b exp %b", i, data_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (data_read !== m_data) begin n_fail++; $display("FAIL sim_data[%0d]: got %h exp %h", i, data_read, m_data); end
      end
      n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL sim_unf[%0d]: got %b exp 1", i, underflow); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sim_ovf[%0d]: got %b exp 0", i, overflow); end
    end
  endtask

  task automatic test_full_boundary();
    logic [DW-1:0] head;
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    head = exp_q[0];
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    n_cmp++; if (data_count !== 6'd31) begin n_fail++; $display("FAIL fb_count: got %0d exp 31", data_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fb_ovf: got %b exp 1", overflow); end
    if (!FWFT) begin
      n_cmp++; if (data_valid !== 1'b1 || data_read !== head) begin n_fail++; $display("FAIL fb_word: got %b/%h exp 1/%h", data_valid, data_read, head); end
    end
    // Dropped write must not appear: remaining 31 words match the model.
    for (int i = 0; i < 31; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      if (m_valid) begin
        n_cmp++; if (data_read !== m_data) begin n_fail++; $display("FAIL fb_rest[%0d]: got %h exp %h", i, data_read, m_data); end
      end
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fb_empty: got %b exp 1", empty); end
  endtask

  task automatic test_reset_mid();
    bit ok_w;
    bit ok_r;
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b1, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    do_reset();
    n_cmp++; if (empty !== 1'b1 || data_count !== 6'd0) begin n_fail++; $display("FAIL rm_state: empty %b count %0d exp 1 0", empty, data_count); end
    n_cmp++; if (almost_empty !== 1'b1 || almost_full !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL rm_flags: ae %b af %b full %b exp 1 0 0", almost_empty, almost_full, full); end
    n_cmp++; if (data_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL rm_outs: v %b o %b u %b exp 0 0 0", data_valid, overflow, underflow); end
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    ok_w = (data_valid === 1'b1) && (data_read === 8'hA5);
    cycle(1'b0, '0, 1'b1, 1'b0);
    ok_r = (data_valid === 1'b1) && (data_read === 8'hA5);
    n_cmp++; if ((FWFT ? ok_w : ok_r) !== 1'b1) begin n_fail++; $display("FAIL rm_a5: got %b/%h exp 1/a5", data_valid, data_read); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rm_empty: got %b exp 1", empty); end
  endtask

  task automatic test_clear_err();
    do_reset();
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i <= DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b1 || underflow !== 1'b1) begin n_fail++; $display("FAIL ce_set: o %b u %b exp 1 1", overflow, underflow); end
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL ce_clr: o %b u %b exp 0 0", overflow, underflow); end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL ce_setwins: got %b exp 1", underflow); end
    n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL ce_ovf: got %b exp %b", overflow, m_ovf); end
  endtask

  task automatic test_random();
    bit w;
    bit r;
    bit c;
    int wp;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      wp = ((i / 100) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < (100 - wp));
      c = ($urandom_range(0, 99) < 5);
      cycle(w, DW'($urandom), r, c);
      n_cmp++; if (data_count !== 6'(exp_q.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d exp %0d", i, data_count, exp_q.size()); end
      n_cmp++; if ({full, empty, almost_full, almost_empty} !== {exp_q.size() == DEPTH, exp_q.size() == 0, exp_q.size() >= AF, exp_q.size() <= AE}) begin
        n_fail++; $display("FAIL rnd_flags[%0d]: got %b%b%b%b size %0d", i, full, empty, almost_full, almost_empty, exp_q.size());
      end
      n_cmp++; if (overflow !== m_ovf || underflow !== m_unf) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b%b exp %b%b", i, overflow, underflow, m_ovf, m_unf); end
      n_cmp++; if (data_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b exp %b", i, data_valid, m_valid); end
      if (m_valid || !FWFT) begin
        n_cmp++; if (data_read !== m_data) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h exp %h", i, data_read, m_data); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    m_data = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_full_boundary();
    test_reset_mid();
    test_clear_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
